program_counter: RTL

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter_pkg.sv | 24 ++
 rtl/tri_state_buffer.sv | 20 ++
 rtl/program_counter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/program_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_pkg
// Description : Shared definitions for the program counter block: bus byte
//               width, reset vector and the data-bus drive selector.
// Revision    : 1.0 - initial release
// ============================================================================
package program_counter_pkg;

    // Width of one CPU data-bus byte lane.
    localparam int unsigned c_data_width = 8;

    // Counter value forced while reset is asserted.
    localparam int unsigned c_reset_pc = 0;

    // Which counter byte (if any) the block places on the shared data bus.
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_LOW  = 2'd1,
        BUS_HIGH = 2'd2
    } bus_sel_e;

endpackage : program_counter_pkg
`default_nettype wire

// File: rtl/tri_state_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tri_state_buffer
// Description : Parameterised tristate driver. Passes i_data through when
//               enabled, otherwise releases the output to high-Z.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_state_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Drive the value only while enabled; float the net otherwise.
    assign o_data = i_en ? i_data : {WIDTH{1'bz}};

endmodule : tri_state_buffer
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : CPU program counter. Increments on INC, accepts a two-byte
//               jump target over the shared data bus (low byte staged first,
//               high byte commits), reads back either byte onto the bus and
//               drives the counter onto a tristate address output. A one-cycle
//               wrap pulse flags roll-over from all-ones to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                    DATA_WIDTH = c_data_width,
    parameter int                    ADDR_WIDTH = 2 * DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(c_reset_pc)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  WE_L,
    input  logic                  WE_H,
    input  logic                  OE_L,
    input  logic                  OE_H,
    input  logic                  INC,
    input  logic                  OE_A,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  pending,
    output logic                  wrap
);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_stage_l;
    logic                  r_pending;
    logic                  r_wrap;

    // ------------------------------------------------------------------------
    // Decoded strobes
    // ------------------------------------------------------------------------
    logic                  w_stage;       // low byte write this edge
    logic                  w_commit;      // high byte write (loads pc) this edge
    logic [DATA_WIDTH-1:0] w_low_src;     // low byte of the jump target
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic                  w_at_max;
    logic [DATA_WIDTH-1:0] w_pc_low;
    logic [DATA_WIDTH-1:0] w_pc_high;
    logic [DATA_WIDTH-1:0] w_bus_value;
    bus_sel_e              w_bus_sel;

    assign w_stage  = CS & WE_L;
    assign w_commit = CS & WE_H;

    // A simultaneous low+high write takes the low byte straight from the bus,
    // so the committed target is {data, data} rather than the stale stage.
    assign w_low_src     = w_stage ? data : r_stage_l;
    assign w_jump_target = ADDR_WIDTH'({data, w_low_src});
    assign w_at_max      = (r_pc == {ADDR_WIDTH{1'b1}});

    // Counter update: a commit wins over INC and the dropped INC is not kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_commit) begin
                r_pc <= w_jump_target;
            end else if (INC) begin
                r_pc   <= r_pc + ADDR_WIDTH'(1);
                r_wrap <= w_at_max;
            end
        end
    end

    // Jump staging: low byte capture and the half-written-target flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage_l <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_stage) begin
                r_stage_l <= data;
            end
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (w_stage) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Data bus read-back
    // ------------------------------------------------------------------------
    assign w_pc_low  = r_pc[DATA_WIDTH-1:0];
    assign w_pc_high = DATA_WIDTH'(r_pc >> DATA_WIDTH);

    // Choose at most one byte lane; asking for both lanes at once is treated
    // as a bus conflict and nothing is driven.
    always_comb begin
        w_bus_sel = BUS_IDLE;
        if (CS && OE_L && !OE_H) begin
            w_bus_sel = BUS_LOW;
        end else if (CS && OE_H && !OE_L) begin
            w_bus_sel = BUS_HIGH;
        end
    end

    assign w_bus_value = (w_bus_sel == BUS_HIGH) ? w_pc_high : w_pc_low;

    // The bus shows the registered counter, so a read and a write on the same
    // edge return the value from before that edge.
    assign data = (w_bus_sel != BUS_IDLE) ? w_bus_value : {DATA_WIDTH{1'bz}};

    // ------------------------------------------------------------------------
    // Address output (not gated by chip select)
    // ------------------------------------------------------------------------
    tri_state_buffer #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr_buf (
        .i_en   (OE_A),
        .i_data (r_pc),
        .o_data (address)
    );

    assign pending = r_pending;
    assign wrap    = r_wrap;

endmodule : program_counter
`default_nettype wire
